uc_arbiter: RTL and testbench

UC_ARBITER -- requirements
Module: uc_arbiter

---
 rtl/uc_arbiter_pkg.sv | 33 +++
 rtl/uc_arbiter_if.sv | 37 +++
 rtl/uc_arbiter_rr_arbiter.sv | 52 +++++
 rtl/uc_arbiter.sv | 135 +++++++++++++
 tb/tb_uc_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_arbiter_pkg.sv
// uc_arbiter_pkg
// Shared types and constants for the unit-clause arbiter.
//   lit_t      : literal, MSB = polarity (1 = negated), low bits = var index
//   ST_*       : arbiter FSM state encodings (exposed on the debug port)
//   lit_var(), lit_neg() : field helpers for lit_t
package uc_arbiter_pkg;

  // Default number of tracked variables; index 0 is reserved as invalid.
  localparam int VAR_MAX_DEFAULT = 64;

  // One extra index bit so that indices >= VAR_MAX are representable and
  // can be detected and dropped.
  localparam int VIDX_W = $clog2(VAR_MAX_DEFAULT) + 1;
  localparam int LIT_W  = VIDX_W + 1;

  typedef logic [LIT_W-1:0] lit_t;

  // FSM state enumeration.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CHECK = 2'd1;
  localparam state_t ST_BCAST = 2'd2;
  localparam state_t ST_CONFL = 2'd3;

  function automatic logic [VIDX_W-1:0] lit_var(input lit_t l);
    return l[VIDX_W-1:0];
  endfunction

  function automatic logic lit_neg(input lit_t l);
    return l[LIT_W-1];
  endfunction

endpackage

// File: rtl/uc_arbiter_if.sv
// uc_arbiter_if
// Bundle of the queue-side signals between the arbiter and the per-PE queues.
//   UCQ_in_empty       : per-PE implication queue empty
//   UCQ_in2uarb_uc     : per-PE head literal of the implication queue
//   ucarb2UCQ_in_pop   : one-hot pop of the selected implication queue
//   UCQ_out_full       : per-PE broadcast queue full
//   ucarb2UCQ_out_push : push into every broadcast queue
//   ucarb2UCQ_out_uc   : broadcast literal
//
// Handshake: an implication queue offers a literal whenever its empty bit is
// low (empty acts as !valid); the literal is consumed on a rising edge where
// its pop bit is high. The broadcast queues accept when all full bits are low
// (full acts as !ready); a push is only raised in that case and the literal
// is consumed by every broadcast queue on that edge.
interface uc_arbiter_if #(parameter int NUM_PE = 4) ();
  import uc_arbiter_pkg::*;

  logic [NUM_PE-1:0]       UCQ_in_empty;
  lit_t [NUM_PE-1:0]       UCQ_in2uarb_uc;
  logic [NUM_PE-1:0]       ucarb2UCQ_in_pop;
  logic [NUM_PE-1:0]       UCQ_out_full;
  logic                    ucarb2UCQ_out_push;
  lit_t                    ucarb2UCQ_out_uc;

  // Arbiter side.
  modport master (
    input  UCQ_in_empty, UCQ_in2uarb_uc, UCQ_out_full,
    output ucarb2UCQ_in_pop, ucarb2UCQ_out_push, ucarb2UCQ_out_uc
  );

  // Queue side.
  modport slave (
    output UCQ_in_empty, UCQ_in2uarb_uc, UCQ_out_full,
    input  ucarb2UCQ_in_pop, ucarb2UCQ_out_push, ucarb2UCQ_out_uc
  );

endinterface

// File: rtl/uc_arbiter_rr_arbiter.sv
// rr_arbiter
// Round-robin requester selection. The search starts at the PE after the
// last one served; the pointer only moves when advance_i is high.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req_i      : request vector
//   advance_i  : commit the current grant and move the pointer past it
//   grant_o    : one-hot grant (all zero when no request)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // (base + off) modulo N, with off < N.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return s[PW-1:0];
  endfunction

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    gnt_idx = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[wrap_add(ptr_q, i)]) begin
        found   = 1'b1;
        gnt_idx = wrap_add(ptr_q, i);
      end
    end
    if (found) grant_o[gnt_idx] = 1'b1;
  end

  assign ptr_d = (advance_i && found) ? wrap_add(gnt_idx, 1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uc_arbiter.sv
// uc_arbiter
// Collects implied literals from NUM_PE implication queues one at a time,
// checks them against a variable assignment table, and broadcasts new
// assignments to every PE. Implying a variable with both polarities sets a
// sticky conflict and parks the arbiter until clear or reset.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous wipe of table, conflict and held literal
//   bus         : queue-side handshake bundle (uc_arbiter_if.master)
//   conflict    : sticky conflict flag
//   idle        : FSM idle and all implication queues empty
//   dbg_state_o : current FSM state
module uc_arbiter #(
  parameter int NUM_PE  = 4,
  parameter int VAR_MAX = uc_arbiter_pkg::VAR_MAX_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  uc_arbiter_if.master bus,
  output logic         conflict,
  output logic         idle,
  output logic [1:0]   dbg_state_o
);
  import uc_arbiter_pkg::*;

  // VAR_MAX must not exceed VAR_MAX_DEFAULT: lit_t is sized from the package.
  localparam int TIDX_W = (VAR_MAX > 1) ? $clog2(VAR_MAX) : 1;

  state_t             state_q, state_d;
  lit_t               lit_q, lit_d;
  logic [VAR_MAX-1:0] assigned_q, assigned_d;
  logic [VAR_MAX-1:0] value_q, value_d;
  logic               conflict_q, conflict_d;

  logic [NUM_PE-1:0]  req, grant;
  logic               do_pop, push_ok;
  lit_t               sel_lit;
  logic [VIDX_W-1:0]  vidx;
  logic [TIDX_W-1:0]  tidx;
  logic               in_range, pol;

  assign req = ~bus.UCQ_in_empty;

  // Pops are gated by rst_n so the pop bus reads zero while reset is held.
  assign do_pop = rst_n && !clear && (state_q == ST_IDLE) && !conflict_q && (|req);

  rr_arbiter #(.N(NUM_PE)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (do_pop),
    .grant_o   (grant)
  );

  always_comb begin
    sel_lit = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant[i]) sel_lit = bus.UCQ_in2uarb_uc[i];
    end
  end

  assign vidx     = lit_var(lit_q);
  assign pol      = lit_neg(lit_q);
  assign tidx     = vidx[TIDX_W-1:0];
  assign in_range = (vidx != '0) && (32'(vidx) < VAR_MAX);
  assign push_ok  = (state_q == ST_BCAST) && !clear && !(|bus.UCQ_out_full);

  always_comb begin
    state_d    = state_q;
    lit_d      = lit_q;
    assigned_d = assigned_q;
    value_d    = value_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_IDLE: begin
        if (do_pop) begin
          lit_d   = sel_lit;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!in_range) begin
          state_d = ST_IDLE;
        end else if (!assigned_q[tidx]) begin
          assigned_d[tidx] = 1'b1;
          value_d[tidx]    = pol;
          state_d          = ST_BCAST;
        end else if (value_q[tidx] == pol) begin
          state_d = ST_IDLE;
        end else begin
          conflict_d = 1'b1;
          state_d    = ST_CONFL;
        end
      end
      ST_BCAST: begin
        // lit_q is left untouched here so the broadcast literal stays stable
        // while the output queues are full.
        if (push_ok) state_d = ST_IDLE;
      end
      ST_CONFL: state_d = ST_CONFL;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d    = ST_IDLE;
      lit_d      = '0;
      assigned_d = '0;
      value_d    = '0;
      conflict_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lit_q      <= '0;
      assigned_q <= '0;
      value_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lit_q      <= lit_d;
      assigned_q <= assigned_d;
      value_q    <= value_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.ucarb2UCQ_in_pop   = do_pop ? grant : '0;
  assign bus.ucarb2UCQ_out_push = push_ok;
  assign bus.ucarb2UCQ_out_uc   = lit_q;
  assign conflict               = conflict_q;
  assign idle                   = (state_q == ST_IDLE) && (&bus.UCQ_in_empty);
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_uc_arbiter.sv
// tb_uc_arbiter
// Directed bench for uc_arbiter with four PE queues modelled as small rings.
module tb_uc_arbiter;
  import uc_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic conflict, idle;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uc_arbiter_if #(.NUM_PE(4)) bus ();

  uc_arbiter #(.NUM_PE(4), .VAR_MAX(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .bus         (bus),
    .conflict    (conflict),
    .idle        (idle),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- PE queue model ----------------
  lit_t       mem [4][16];
  logic [3:0] head [4];
  logic [3:0] tail [4];
  logic [3:0] pop_s;

  // ---------------- scoreboard ----------------
  logic [LIT_W-1:0] exp_q[$];
  logic [LIT_W-1:0] exp_lit;

  // Pops and pushes are sampled mid-cycle; stimulus only changes just after
  // the rising edge, so these values are the ones the next edge acts on.
  always @(negedge clk) begin
    pop_s = bus.ucarb2UCQ_in_pop;
    if (rst_n) begin
      total++;
      if ((|bus.ucarb2UCQ_in_pop) && bus.ucarb2UCQ_out_push) begin
        bad++;
        $display("FAIL pop_push_overlap: pop=%b push=%b, required not both", bus.ucarb2UCQ_in_pop, bus.ucarb2UCQ_out_push);
      end
      if (bus.ucarb2UCQ_out_push) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bcast_unexpected: got push uc=%h, required no push", bus.ucarb2UCQ_out_uc);
        end else begin
          exp_lit = exp_q.pop_front();
          if (bus.ucarb2UCQ_out_uc !== exp_lit) begin
            bad++;
            $display("FAIL bcast_lit: got %h want %h", bus.ucarb2UCQ_out_uc, exp_lit);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.UCQ_in_empty[i]   = (head[i] == tail[i]);
      bus.UCQ_in2uarb_uc[i] = (head[i] == tail[i]) ? '0 : mem[i][head[i]];
    end
  endtask

  task automatic load(input int pe, input lit_t l);
    mem[pe][tail[pe]] = l;
    tail[pe] = tail[pe] + 4'd1;
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) head[i] = tail[i];
    drive();
  endtask

  // Advance one cycle; apply the pops the DUT issued on that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (pop_s[i] && head[i] != tail[i]) head[i] = head[i] + 4'd1;
    drive();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL rst_pop: got %b want 0000", bus.ucarb2UCQ_in_pop); end
    total++; if (bus.ucarb2UCQ_out_push !== 1'b0) begin bad++; $display("FAIL rst_push: got %b want 0", bus.ucarb2UCQ_out_push); end
    total++; if (bus.ucarb2UCQ_out_uc !== 8'h00) begin bad++; $display("FAIL rst_uc: got %h want 00", bus.ucarb2UCQ_out_uc); end
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL rst_conflict: got %b want 0", conflict); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    load(0, 8'h01);
    #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL rst_pop_req: got %b want 0000", bus.ucarb2UCQ_in_pop); end
    flush();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    load(1, 8'h05); exp_q.push_back(8'h05); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0010) begin bad++; $display("FAIL single_pop: got %b want 0010", bus.ucarb2UCQ_in_pop); end
    tick();
    total++; if (dbg_state !== ST_CHECK) begin bad++; $display("FAIL single_check: got %0d want 1", dbg_state); end
    total++; if (bus.ucarb2UCQ_out_push !== 1'b0) begin bad++; $display("FAIL single_push_c1: got %b want 0", bus.ucarb2UCQ_out_push); end
    tick();
    total++; if (bus.ucarb2UCQ_out_push !== 1'b1) begin bad++; $display("FAIL single_push_c2: got %b want 1", bus.ucarb2UCQ_out_push); end
    total++; if (bus.ucarb2UCQ_out_uc !== 8'h05) begin bad++; $display("FAIL single_uc: got %h want 05", bus.ucarb2UCQ_out_uc); end
    tick();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle_c3: got %b want 1", idle); end
  endtask

  task automatic test_dup();
    load(0, 8'h07); load(2, 8'h07); exp_q.push_back(8'h07); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0100) begin bad++; $display("FAIL dup_pop1: got %b want 0100", bus.ucarb2UCQ_in_pop); end
    tick(); tick();
    total++; if (bus.ucarb2UCQ_out_push !== 1'b1) begin bad++; $display("FAIL dup_push1: got %b want 1", bus.ucarb2UCQ_out_push); end
    tick();
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0001) begin bad++; $display("FAIL dup_pop2: got %b want 0001", bus.ucarb2UCQ_in_pop); end
    tick(); tick();
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL dup_state: got %0d want 0", dbg_state); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL dup_idle: got %b want 1", idle); end
  endtask

  task automatic test_bcast_full();
    load(3, 8'h09); exp_q.push_back(8'h09); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b1000) begin bad++; $display("FAIL full_pop: got %b want 1000", bus.ucarb2UCQ_in_pop); end
    tick();
    bus.UCQ_out_full = 4'b0100;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (bus.ucarb2UCQ_out_push !== 1'b0) begin bad++; $display("FAIL full_hold_push%0d: got %b want 0", k, bus.ucarb2UCQ_out_push); end
      total++; if (bus.ucarb2UCQ_out_uc !== 8'h09) begin bad++; $display("FAIL full_hold_uc%0d: got %h want 09", k, bus.ucarb2UCQ_out_uc); end
      tick();
    end
    bus.UCQ_out_full = 4'b0000;
    #1;
    total++; if (bus.ucarb2UCQ_out_push !== 1'b1) begin bad++; $display("FAIL full_release_push: got %b want 1", bus.ucarb2UCQ_out_push); end
    tick();
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL full_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_rr();
    logic [3:0] exp_pop;
    int cyc;
    load(0, 8'h0A); load(0, 8'h0E);
    load(1, 8'h0B); load(1, 8'h0F);
    load(2, 8'h0C); load(2, 8'h10);
    load(3, 8'h0D); load(3, 8'h11);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B); exp_q.push_back(8'h0C); exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0E); exp_q.push_back(8'h0F); exp_q.push_back(8'h10); exp_q.push_back(8'h11);
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_pop = 4'(1 << (n % 4));
      total++; if (bus.ucarb2UCQ_in_pop !== exp_pop) begin bad++; $display("FAIL rr_pop%0d: got %b want %b", n, bus.ucarb2UCQ_in_pop, exp_pop); end
      tick();
      total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d_a: got %b want 0000", n, bus.ucarb2UCQ_in_pop); end
      tick();
      total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d_b: got %b want 0000", n, bus.ucarb2UCQ_in_pop); end
      tick();
    end
    cyc = 0;
    while (!idle && cyc < 60) begin
      tick();
      cyc++;
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rr_drain_timeout: idle=%b after %0d cycles, required 1", idle, cyc); end
    total++; if (cyc !== 9) begin bad++; $display("FAIL rr_drain_cycles: got %0d want 9", cyc); end
  endtask

  task automatic test_conflict();
    load(0, 8'h03); exp_q.push_back(8'h03); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0001) begin bad++; $display("FAIL confl_pop1: got %b want 0001", bus.ucarb2UCQ_in_pop); end
    tick(); tick(); tick();
    load(3, 8'h83); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b1000) begin bad++; $display("FAIL confl_pop2: got %b want 1000", bus.ucarb2UCQ_in_pop); end
    tick();
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL confl_early: got %b want 0", conflict); end
    tick();
    total++; if (conflict !== 1'b1) begin bad++; $display("FAIL confl_rise: got %b want 1", conflict); end
    load(1, 8'h14); #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL confl_pop_hold%0d: got %b want 0000", k, bus.ucarb2UCQ_in_pop); end
      total++; if (conflict !== 1'b1) begin bad++; $display("FAIL confl_hold%0d: got %b want 1", k, conflict); end
      total++; if (dbg_state !== ST_CONFL) begin bad++; $display("FAIL confl_state%0d: got %0d want 3", k, dbg_state); end
      tick();
    end
  endtask

  task automatic test_clear_reset();
    // clear out of CONFL, then re-send +3
    flush();
    load(2, 8'h03);
    clear = 1'b1; #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL clr_pop_confl: got %b want 0000", bus.ucarb2UCQ_in_pop); end
    tick();
    clear = 1'b0; #1;
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL clr_conflict: got %b want 0", conflict); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL clr_state: got %0d want 0", dbg_state); end
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0100) begin bad++; $display("FAIL clr_resend_pop: got %b want 0100", bus.ucarb2UCQ_in_pop); end
    exp_q.push_back(8'h03);
    tick(); tick();
    total++; if (bus.ucarb2UCQ_out_push !== 1'b1) begin bad++; $display("FAIL clr_resend_push: got %b want 1", bus.ucarb2UCQ_out_push); end
    tick();
    // clear beats a pending pop in IDLE
    load(0, 8'h15);
    clear = 1'b1; #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0000) begin bad++; $display("FAIL clr_pop_idle: got %b want 0000", bus.ucarb2UCQ_in_pop); end
    tick();
    clear = 1'b0; #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0001) begin bad++; $display("FAIL clr_pop_after: got %b want 0001", bus.ucarb2UCQ_in_pop); end
    exp_q.push_back(8'h15);
    tick(); tick(); tick();
    // reset while a broadcast is being held
    load(1, 8'h16); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0010) begin bad++; $display("FAIL rstb_pop: got %b want 0010", bus.ucarb2UCQ_in_pop); end
    tick();
    bus.UCQ_out_full = 4'b0001;
    tick();
    total++; if (dbg_state !== ST_BCAST) begin bad++; $display("FAIL rstb_state: got %0d want 2", dbg_state); end
    total++; if (bus.ucarb2UCQ_out_uc !== 8'h16) begin bad++; $display("FAIL rstb_uc_held: got %h want 16", bus.ucarb2UCQ_out_uc); end
    rst_n = 1'b0; #1;
    total++; if (bus.ucarb2UCQ_out_push !== 1'b0) begin bad++; $display("FAIL rstb_push: got %b want 0", bus.ucarb2UCQ_out_push); end
    total++; if (bus.ucarb2UCQ_out_uc !== 8'h00) begin bad++; $display("FAIL rstb_uc: got %h want 00", bus.ucarb2UCQ_out_uc); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rstb_state_idle: got %0d want 0", dbg_state); end
    bus.UCQ_out_full = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (bus.ucarb2UCQ_out_push !== 1'b0) begin bad++; $display("FAIL rstb_no_reissue%0d: got %b want 0", k, bus.ucarb2UCQ_out_push); end
    end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rstb_idle: got %b want 1", idle); end
  endtask

  task automatic test_invalid();
    load(0, 8'h80); load(1, 8'h40); load(1, 8'hC0); #1;
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0001) begin bad++; $display("FAIL inv_pop0: got %b want 0001", bus.ucarb2UCQ_in_pop); end
    tick(); tick();
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0010) begin bad++; $display("FAIL inv_pop1: got %b want 0010", bus.ucarb2UCQ_in_pop); end
    tick(); tick();
    total++; if (bus.ucarb2UCQ_in_pop !== 4'b0010) begin bad++; $display("FAIL inv_pop2: got %b want 0010", bus.ucarb2UCQ_in_pop); end
    tick(); tick();
    total++; if (conflict !== 1'b0) begin bad++; $display("FAIL inv_conflict: got %b want 0", conflict); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL inv_idle: got %b want 1", idle); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    pop_s = '0;
    bus.UCQ_out_full = '0;
    for (int i = 0; i < 4; i++) begin head[i] = '0; tail[i] = '0; end
    drive();
    test_reset();
    test_single();
    test_dup();
    test_bcast_full();
    test_rr();
    test_conflict();
    test_clear_reset();
    test_invalid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bcast_missing: %0d expected broadcasts not seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
